selection_sort_engine: RTL and testbench
========================================

// Module: selection_sort_engine
// PURPOSE
//  Parametrised in-place selection sorter. Masters an external single-port RAM (1-cycle registered read).
//  Sorts a window of i_num_elems words starting at i_base_addr.
//  Sort order and signedness are chosen per run; the swap count is reported.
//  Sits beside the RAM in the sort top level and is driven by a host start/done handshake.
// PARAMETERS
//  SIZE_ADDR  8  RAM address width; window addresses wrap modulo 2**SIZE_ADDR
//  SIZE_DATA  8  element width
//  SIZE_CNT   16 width of o_swap_cnt
// PORTS
//  i_clk         in   1            clock, rising edge
//  i_rst_n       in   1            reset, synchronous, active-low
//  i_start       in   1            start pulse; sampled only in IDLE
//  i_base_addr   in   SIZE_ADDR    first element address
//  i_num_elems   in   SIZE_ADDR+1  element count, 0..2**SIZE_ADDR
//  i_descending  in   1            0: ascending, 1: descending
//  i_signed      in   1            1: two's-complement compare
//  o_busy        out  1            high from the cycle after start is accepted through DONE
//  o_done        out  1            one-cycle pulse when the run is complete
//  o_swap_cnt    out  SIZE_CNT     swaps in the last run; saturates at all-ones
//  o_ram_rd_en   out  1            RAM read strobe
//  o_ram_wr_en   out  1            RAM write strobe
//  o_ram_addr    out  SIZE_ADDR    RAM address
//  o_ram_wdata   out  SIZE_DATA    RAM write data
//  i_ram_rdata   in   SIZE_DATA    RAM read data; valid the cycle after o_ram_rd_en
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge):
//   - state goes to IDLE; every output is 0 (including o_swap_cnt).
//   - Reset mid-run aborts at once; no further RAM access is made.
//  Start:
//   - i_start in IDLE latches base, n, descending and signed; clears swap_cnt.
//   - i_start while busy is ignored.
//   - RAM strobes are mutually exclusive. Address = base+idx, truncated to SIZE_ADDR (wraps).
//  FSM:
//   - IDLE -> (start, n<2) DONE; (start, n>=2) RD_I with i=0.
//   - RD_I: rd addr base+i -> LAT_I.
//   - LAT_I: val_i=min_val=rdata, min_idx=i, j=i+1 -> RD_J.
//   - RD_J: rd addr base+j -> CMP_J.
//   - CMP_J: if better(rdata,min_val) then min_val=rdata, min_idx=j.
//       if j==n-1: go to WR_I when min_idx!=i (use the updated value); otherwise NEXT.
//       else j++ -> RD_J.
//   - WR_I: wr base+i <= min_val -> WR_M.
//   - WR_M: wr base+min_idx <= val_i; swap_cnt++ (saturating) -> NEXT.
//   - NEXT (folded into transition): if i==n-2 -> DONE, else i++ -> RD_I.
//   - DONE: o_done=1 for one cycle -> IDLE. o_swap_cnt holds until the next start.
//  Compare (better):
//   - strict less-than (ascending) or strict greater-than (descending).
//   - Signed or unsigned per i_signed.
//   - Equal values never displace the current min, so the first occurrence wins.
//  Latency:
//   - per i: 2 + 2*(n-1-i) + (swap ? 2 : 0) cycles, plus 1 DONE cycle.
//   - n<2: o_done in the cycle after start; no RAM access.
//  Widths:
//   - i, j, min_idx are SIZE_ADDR+1 bits, so n = 2**SIZE_ADDR is handled without overflow.
// STRUCTURE
//  sort_pkg:
//   - typedef enum sort_state_t {IDLE,RD_I,LAT_I,RD_J,CMP_J,WR_I,WR_M,DONE}
//   - localparams for order/sign mode bits
//  Sub-module sort_cmp: combinational better() over SIZE_DATA with i_signed/i_descending.
//  FSM, indices and registers live in selection_sort_engine.
//  Bench RAM model: SinglePort_RAM.
// TESTING
//  1. Ascending, unsigned, base=0, [3,1,4,2]:
//     -> RAM [1,2,3,4]; o_swap_cnt=3; o_done pulses 25 cycles after the start edge.
//  2. Values [80,7F,00] hex, ascending:
//     signed -> [80,00,7F]; unsigned -> [00,7F,80].
//  3. Descending on [9,7,5]:
//     -> o_ram_wr_en never high; swap_cnt=0; contents unchanged.
//  4. Duplicates [2,2,1], ascending:
//     -> [1,2,2]; swap_cnt=1; the i=1 pass issues no write.
//  5. base=FE, n=4, SIZE_ADDR=8:
//     -> only addresses FE,FF,00,01 are touched; sorted result is correct.
//     n=0 and n=1 -> o_done in the next cycle; no RAM strobes.
//  6. i_rst_n=0 during CMP_J:
//     -> outputs 0 at the next edge; IDLE.
//     A second i_start while busy is ignored (swap_cnt and addresses unaffected).

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the selection sort engine.
//  - sort_state_t : FSM state encoding (also driven out on the debug state port)
//  - ORDER_* / CMP_* : meaning of the i_descending / i_signed mode bits
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    LAT_I = 3'd2,
    RD_J  = 3'd3,
    CMP_J = 3'd4,
    WR_I  = 3'd5,
    WR_M  = 3'd6,
    DONE  = 3'd7
  } sort_state_t;

  localparam logic ORDER_ASC    = 1'b0;
  localparam logic ORDER_DESC   = 1'b1;
  localparam logic CMP_UNSIGNED = 1'b0;
  localparam logic CMP_SIGNED   = 1'b1;

endpackage

// File: rtl/sort_cmp.sv
// Combinational "better" test for the selection sort engine.
// Ports:
//  i_cand       candidate value (just read from RAM)
//  i_best       current best (min for ascending, max for descending)
//  i_signed     1: two's-complement compare, 0: unsigned
//  i_descending 1: strict greater-than wins, 0: strict less-than wins
//  o_better     1 when i_cand must replace i_best
// Equal values never win, so the first occurrence of the extreme is kept.
module sort_cmp
  import sort_pkg::*;
#(
  parameter int SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] i_cand,
  input  logic [SIZE_DATA-1:0] i_best,
  input  logic                 i_signed,
  input  logic                 i_descending,
  output logic                 o_better
);

  logic lt;
  logic gt;

  always_comb begin
    if (i_signed == CMP_SIGNED) begin
      lt = $signed(i_cand) < $signed(i_best);
      gt = $signed(i_cand) > $signed(i_best);
    end else begin
      lt = i_cand < i_best;
      gt = i_cand > i_best;
    end
    o_better = (i_descending == ORDER_DESC) ? gt : lt;
  end

endmodule

// File: rtl/selection_sort_engine.sv
// In-place selection sorter mastering a single-port RAM with 1-cycle registered read.
// Ports:
//  i_clk, i_rst_n           clock (rising edge), synchronous active-low reset
//  i_start                  start pulse, sampled only in IDLE
//  i_base_addr, i_num_elems window start address and element count (0..2**SIZE_ADDR)
//  i_descending, i_signed   sort order and compare signedness for the run
//  o_busy, o_done           busy from the cycle after start through DONE; one-cycle done pulse
//  o_swap_cnt               swaps in the last run (saturating), held until the next start
//  o_ram_*                  RAM read/write strobes, address, write data
//  i_ram_rdata              RAM read data, valid the cycle after o_ram_rd_en
//  o_dbg_state              current FSM state
// Handshake: the host raises i_start for one cycle while o_busy is low; the parameters are
// captured on that edge; o_done pulses once when the window is sorted. Starts while busy
// are dropped.
// All outputs are registered: the RAM controls for a state are decoded from the next state
// so that the strobe is on the bus during that state's cycle.
module selection_sort_engine
  import sort_pkg::*;
#(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8,
  parameter int SIZE_CNT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_base_addr,
  input  logic [SIZE_ADDR:0]   i_num_elems,
  input  logic                 i_descending,
  input  logic                 i_signed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [SIZE_CNT-1:0]  o_swap_cnt,
  output logic                 o_ram_rd_en,
  output logic                 o_ram_wr_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_ram_wdata,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic [2:0]           o_dbg_state
);

  localparam logic [SIZE_ADDR:0]  IDX_ONE = 1;
  localparam logic [SIZE_ADDR:0]  IDX_TWO = 2;
  localparam logic [SIZE_CNT-1:0] CNT_ONE = 1;

  sort_state_t          state_q, state_d;
  logic [SIZE_ADDR-1:0] base_q, base_d;
  logic [SIZE_ADDR:0]   n_q, n_d;
  logic                 desc_q, desc_d;
  logic                 signed_q, signed_d;
  logic [SIZE_ADDR:0]   i_q, i_d;
  logic [SIZE_ADDR:0]   j_q, j_d;
  logic [SIZE_ADDR:0]   min_idx_q, min_idx_d;
  logic [SIZE_DATA-1:0] min_val_q, min_val_d;
  logic [SIZE_DATA-1:0] val_i_q, val_i_d;
  logic [SIZE_CNT-1:0]  swap_cnt_q, swap_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d;
  logic [SIZE_DATA-1:0] wdata_q, wdata_d;

  logic better;
  logic last_pass;

  sort_cmp #(.SIZE_DATA(SIZE_DATA)) u_cmp (
    .i_cand       (i_ram_rdata),
    .i_best       (min_val_q),
    .i_signed     (signed_q),
    .i_descending (desc_q),
    .o_better     (better)
  );

  // i == n-2 is the final outer pass (n >= 2 whenever this is consulted).
  assign last_pass = (i_q == n_q - IDX_TWO);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    n_d        = n_q;
    desc_d     = desc_q;
    signed_d   = signed_q;
    i_d        = i_q;
    j_d        = j_q;
    min_idx_d  = min_idx_q;
    min_val_d  = min_val_q;
    val_i_d    = val_i_q;
    swap_cnt_d = swap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          base_d     = i_base_addr;
          n_d        = i_num_elems;
          desc_d     = i_descending;
          signed_d   = i_signed;
          swap_cnt_d = '0;
          i_d        = '0;
          state_d    = (i_num_elems < IDX_TWO) ? DONE : RD_I;
        end
      end
      RD_I: state_d = LAT_I;
      LAT_I: begin
        val_i_d   = i_ram_rdata;
        min_val_d = i_ram_rdata;
        min_idx_d = i_q;
        j_d       = i_q + IDX_ONE;
        state_d   = RD_J;
      end
      RD_J: state_d = CMP_J;
      CMP_J: begin
        if (better) begin
          min_val_d = i_ram_rdata;
          min_idx_d = j_q;
        end
        if (j_q == n_q - IDX_ONE) begin
          // Decide on the post-compare min_idx so a last-element winner still swaps.
          if (min_idx_d != i_q) begin
            state_d = WR_I;
          end else if (last_pass) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + IDX_ONE;
            state_d = RD_I;
          end
        end else begin
          j_d     = j_q + IDX_ONE;
          state_d = RD_J;
        end
      end
      WR_I: state_d = WR_M;
      WR_M: begin
        if (swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + CNT_ONE;
        if (last_pass) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + IDX_ONE;
          state_d = RD_I;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs for the cycle spent in state_d.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == RD_I) || (state_d == RD_J);
    wr_en_d = (state_d == WR_I) || (state_d == WR_M);
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      RD_I:    addr_d = base_d + i_d[SIZE_ADDR-1:0];
      RD_J:    addr_d = base_d + j_d[SIZE_ADDR-1:0];
      WR_I: begin
        addr_d  = base_d + i_d[SIZE_ADDR-1:0];
        wdata_d = min_val_d;
      end
      WR_M: begin
        addr_d  = base_d + min_idx_d[SIZE_ADDR-1:0];
        wdata_d = val_i_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      n_q        <= '0;
      desc_q     <= 1'b0;
      signed_q   <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      min_idx_q  <= '0;
      min_val_q  <= '0;
      val_i_q    <= '0;
      swap_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      n_q        <= n_d;
      desc_q     <= desc_d;
      signed_q   <= signed_d;
      i_q        <= i_d;
      j_q        <= j_d;
      min_idx_q  <= min_idx_d;
      min_val_q  <= min_val_d;
      val_i_q    <= val_i_d;
      swap_cnt_q <= swap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_swap_cnt  = swap_cnt_q;
  assign o_ram_rd_en = rd_en_q;
  assign o_ram_wr_en = wr_en_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_selection_sort_engine.sv
// Directed bench for selection_sort_engine with an in-bench single-port RAM model
// (SinglePort_RAM behaviour: registered 1-cycle read, synchronous write).
module tb_selection_sort_engine;
  import sort_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  num_elems = '0;
  logic        descending = 1'b0;
  logic        sgn = 1'b0;
  logic        busy, done;
  logic [15:0] swap_cnt;
  logic        ram_rd_en, ram_wr_en;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  selection_sort_engine dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_num_elems  (num_elems),
    .i_descending (descending),
    .i_signed     (sgn),
    .o_busy       (busy),
    .o_done       (done),
    .o_swap_cnt   (swap_cnt),
    .o_ram_rd_en  (ram_rd_en),
    .o_ram_wr_en  (ram_wr_en),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata),
    .o_dbg_state  (dbg_state)
  );

  // RAM model (SinglePort_RAM)
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
    if (ram_wr_en) mem[ram_addr] = ram_wdata;
  end

  // Bus monitor: strobe counts and accesses outside the current window.
  int         strobe_cnt = 0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  int         out_win = 0;
  logic [7:0] win_base = '0;
  int         win_n = 0;
  logic [7:0] mon_off;
  always @(posedge clk) begin
    mon_off = ram_addr - win_base;
    if (ram_rd_en || ram_wr_en) begin
      strobe_cnt++;
      if (int'(mon_off) >= win_n) out_win++;
    end
    if (ram_wr_en) wr_cnt++;
    if (ram_rd_en && ram_wr_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input logic [7:0] b, input int n);
    strobe_cnt = 0;
    wr_cnt     = 0;
    both_cnt   = 0;
    out_win    = 0;
    win_base   = b;
    win_n      = n;
  endtask

  // Pulse start for one cycle; returns at start edge + 1.
  task automatic kick(input logic [7:0] b, input int n, input logic d, input logic s);
    @(negedge clk);
    base_addr  = b;
    num_elems  = 9'(n);
    descending = d;
    sgn        = s;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the one right after the start edge; returns the cycle o_done is seen.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] b, input int n,
                     input logic d, input logic s, output int cyc);
    clear_mon(b, n);
    kick(b, n, d, s);
    wait_done(tag, cyc);
    @(posedge clk);
    #1;
  endtask

  int cyc;
  int snap;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'hAA;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_swap", 32'(swap_cnt), 0);
    chk("rst_strobes", 32'({ram_rd_en, ram_wr_en}), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // 1. ascending unsigned [3,1,4,2] -> [1,2,3,4], 3 swaps, done at cycle 25
    mem[0] = 8'd3; mem[1] = 8'd1; mem[2] = 8'd4; mem[3] = 8'd2;
    clear_mon(8'h00, 4);
    kick(8'h00, 4, 1'b0, 1'b0);
    chk("t1_busy", 32'(busy), 1);
    wait_done("t1", cyc);
    chk("t1_latency", 32'(cyc), 25);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_m0", 32'(mem[0]), 1);
    chk("t1_m1", 32'(mem[1]), 2);
    chk("t1_m2", 32'(mem[2]), 3);
    chk("t1_m3", 32'(mem[3]), 4);
    chk("t1_swaps", 32'(swap_cnt), 3);
    chk("t1_wr_cnt", 32'(wr_cnt), 6);
    chk("t1_exclusive", 32'(both_cnt), 0);

    // 2. [80,7F,00] signed -> [80,00,7F]; unsigned -> [00,7F,80]
    mem[16] = 8'h80; mem[17] = 8'h7F; mem[18] = 8'h00;
    run("t2s", 8'h10, 3, 1'b0, 1'b1, cyc);
    chk("t2s_m0", 32'(mem[16]), 32'h80);
    chk("t2s_m1", 32'(mem[17]), 32'h00);
    chk("t2s_m2", 32'(mem[18]), 32'h7F);
    chk("t2s_swaps", 32'(swap_cnt), 1);
    mem[16] = 8'h80; mem[17] = 8'h7F; mem[18] = 8'h00;
    run("t2u", 8'h10, 3, 1'b0, 1'b0, cyc);
    chk("t2u_m0", 32'(mem[16]), 32'h00);
    chk("t2u_m1", 32'(mem[17]), 32'h7F);
    chk("t2u_m2", 32'(mem[18]), 32'h80);
    chk("t2u_swaps", 32'(swap_cnt), 1);

    // 3. descending on already-descending [9,7,5]: no writes
    mem[32] = 8'd9; mem[33] = 8'd7; mem[34] = 8'd5;
    run("t3", 8'h20, 3, 1'b1, 1'b0, cyc);
    chk("t3_wr_cnt", 32'(wr_cnt), 0);
    chk("t3_swaps", 32'(swap_cnt), 0);
    chk("t3_m", 32'({mem[32], mem[33], mem[34]}), 32'h090705);
    // 2 + 2*2 + 2 + 2*1 + 1
    chk("t3_latency", 32'(cyc), 11);

    // 4. duplicates [2,2,1] -> [1,2,2]; only the i=0 swap writes
    mem[48] = 8'd2; mem[49] = 8'd2; mem[50] = 8'd1;
    run("t4", 8'h30, 3, 1'b0, 1'b0, cyc);
    chk("t4_m", 32'({mem[48], mem[49], mem[50]}), 32'h010202);
    chk("t4_swaps", 32'(swap_cnt), 1);
    chk("t4_wr_cnt", 32'(wr_cnt), 2);

    // 5. wrap: base FE, n=4, [4,3,2,1] -> [1,2,3,4], 2 swaps, neighbours untouched
    mem[8'hFD] = 8'h5A; mem[8'h02] = 8'hA5;
    mem[8'hFE] = 8'd4; mem[8'hFF] = 8'd3; mem[8'h00] = 8'd2; mem[8'h01] = 8'd1;
    run("t5", 8'hFE, 4, 1'b0, 1'b0, cyc);
    chk("t5_m", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h01020304);
    chk("t5_swaps", 32'(swap_cnt), 2);
    chk("t5_out_win", 32'(out_win), 0);
    chk("t5_neigh", 32'({mem[8'hFD], mem[8'h02]}), 32'h5AA5);

    // n=0 and n=1: done right after start, no RAM access
    run("t5n0", 8'h00, 0, 1'b0, 1'b0, cyc);
    chk("t5n0_latency", 32'(cyc), 1);
    chk("t5n0_strobes", 32'(strobe_cnt), 0);
    chk("t5n0_swaps", 32'(swap_cnt), 0);
    run("t5n1", 8'h00, 1, 1'b0, 1'b0, cyc);
    chk("t5n1_latency", 32'(cyc), 1);
    chk("t5n1_strobes", 32'(strobe_cnt), 0);

    // 6a. reset during CMP_J
    mem[64] = 8'd3; mem[65] = 8'd1; mem[66] = 8'd4; mem[67] = 8'd2;
    clear_mon(8'h40, 4);
    kick(8'h40, 4, 1'b0, 1'b0);
    cyc = 0;
    while (dbg_state != 3'(CMP_J) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t6_reach_cmp", 32'(dbg_state), 32'(CMP_J));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_outs", 32'({busy, done, ram_rd_en, ram_wr_en}), 0);
    chk("t6_addr_data", 32'({ram_addr, ram_wdata}), 0);
    chk("t6_swap", 32'(swap_cnt), 0);
    snap = strobe_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_access", 32'(strobe_cnt - snap), 0);
    chk("t6_mem_untouched", {mem[64], mem[65], mem[66], mem[67]}, 32'h03010402);

    // 6b. second start while busy is ignored
    clear_mon(8'h40, 4);
    kick(8'h40, 4, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    kick(8'h80, 2, 1'b1, 1'b1);
    wait_done("t6b", cyc);
    @(posedge clk);
    #1;
    chk("t6b_m", {mem[64], mem[65], mem[66], mem[67]}, 32'h01020304);
    chk("t6b_swaps", 32'(swap_cnt), 3);
    chk("t6b_out_win", 32'(out_win), 0);
    chk("t6b_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
